// File: rtl/display_share_arbiter.sv
// Two-requester time-slicing arbiter for the shared 4-digit seven-segment display.
// The current owner's data is registered and sanitized into bcd_out one cycle later.
module display_share_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [15:0] bcd_out,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             valid_q, valid_d;

    // Non-decimal nibbles would light garbage segments; blank them to zero.
    function automatic logic [15:0] sanitize(input logic [15:0] d);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (d[4*i +: 4] > 4'd9) ? 4'h0 : d[4*i +: 4];
        end
        return r;
    endfunction

    // State register; last_q resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!req0) begin
                    state_d = req1 ? StOwn1 : StIdle;
                end else if (req1 && (cnt_q == CntMax)) begin
                    state_d = StOwn1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOwn1: begin
                if (!req1) begin
                    state_d = req0 ? StOwn0 : StIdle;
                end else if (req0 && (cnt_q == CntMax)) begin
                    state_d = StOwn0;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Any entry into an owned state restarts the hold window.
        if ((state_d != state_q) && (state_d != StIdle)) begin
            cnt_d  = '0;
            last_d = (state_d == StOwn1);
        end
    end

    always_comb begin
        gnt0    = (state_q == StOwn0);
        gnt1    = (state_q == StOwn1);
        bcd_out = bcd_q;
        valid_o = valid_q;
    end

    // Datapath: sample the owner's word every owned cycle, hold it while idle.
    always_comb begin
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        unique case (state_q)
            StOwn0: begin
                bcd_d   = sanitize(data0);
                valid_d = 1'b1;
            end
            StOwn1: begin
                bcd_d   = sanitize(data1);
                valid_d = 1'b1;
            end
            default: begin
                bcd_d   = bcd_q;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Randomized scoreboard bench for display_share_arbiter with a cycle-level ownership model.
module tb_display_share_arbiter;

    localparam int unsigned Hold = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0 = 1'b0;
    logic        r1 = 1'b0;
    logic [15:0] d0 = 16'h0;
    logic [15:0] d1 = 16'h0;
    logic        gnt0, gnt1, valid_o;
    logic [15:0] bcd_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic        g0;
        logic        g1;
        logic        v;
        logic [15:0] bcd;
    } exp_t;

    exp_t sb[$];

    // Model: owner 0 = nobody, 1 = requester 0, 2 = requester 1.
    int          m_owner;
    int          m_held;
    int          m_last;
    logic [15:0] m_bcd;
    logic        m_valid;

    display_share_arbiter #(
        .HOLD_CYCLES(Hold)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (r0),
        .data0  (d0),
        .req1   (r1),
        .data1  (d1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .bcd_out(bcd_out),
        .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] san(input logic [15:0] d);
        int n;
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            n = (int'(d) >> (4 * i)) % 16;
            if (n <= 9) r = r + (n << (4 * i));
        end
        return 16'(r);
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_held  = 0;
        m_last  = 2;
        m_bcd   = 16'h0;
        m_valid = 1'b0;
    endtask

    task automatic take(input int who);
        m_owner = who;
        m_held  = 1;
        m_last  = who;
    endtask

    // Advance the model across the next clock edge using the currently driven inputs.
    task automatic model_edge();
        exp_t e;
        int   other;
        bit   want_me;
        bit   want_other;
        if (m_owner == 1) m_bcd = san(d0);
        else if (m_owner == 2) m_bcd = san(d1);
        m_valid = (m_owner != 0);
        if (m_owner == 0) begin
            if (r0 && r1) take(m_last == 1 ? 2 : 1);
            else if (r0) take(1);
            else if (r1) take(2);
        end else begin
            other      = (m_owner == 1) ? 2 : 1;
            want_me    = (m_owner == 1) ? r0 : r1;
            want_other = (m_owner == 1) ? r1 : r0;
            if (!want_me) begin
                if (want_other) take(other);
                else m_owner = 0;
            end else if (want_other && m_held >= Hold) begin
                take(other);
            end else begin
                m_held++;
            end
        end
        e.cyc = cyc + 1;
        e.g0  = (m_owner == 1);
        e.g1  = (m_owner == 2);
        e.v   = m_valid;
        e.bcd = m_bcd;
        sb.push_back(e);
    endtask

    task automatic step(input logic a, input logic [15:0] da, input logic b,
                        input logic [15:0] db);
        @(posedge clk);
        #1;
        r0 = a;
        d0 = da;
        r1 = b;
        d1 = db;
        model_edge();
    endtask

    // Pulse reset between edges and check the asynchronous clear before the next edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        sb.delete();
        model_reset();
        #1;
        rst = 1'b0;
        model_edge();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("sb_stale", 32'(e.cyc), 32'(cyc));
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("gnt0", 32'(gnt0), 32'(e.g0));
                chk("gnt1", 32'(gnt1), 32'(e.g1));
                chk("valid_o", 32'(valid_o), 32'(e.v));
                chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
                chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
            end
        end
    end

    initial begin : stimulus
        logic a, b;
        logic [15:0] da, db;
        @(posedge clk);
        #1;
        do_reset();
        // Single request
        repeat (4) step(1'b1, 16'h1234, 1'b0, 16'h0000);
        repeat (2) step(1'b0, 16'h1234, 1'b0, 16'h0000);
        // Time slicing with both held
        repeat (20) step(1'b1, 16'h1234, 1'b1, 16'h5678);
        repeat (2) step(1'b0, 16'h1234, 1'b0, 16'h5678);
        // Early release with and without a waiting requester
        step(1'b1, 16'h1234, 1'b0, 16'h5678);
        repeat (2) step(1'b1, 16'h1234, 1'b1, 16'h5678);
        repeat (3) step(1'b0, 16'h1234, 1'b1, 16'h5678);
        repeat (2) step(1'b0, 16'h1234, 1'b0, 16'h5678);
        repeat (3) step(1'b1, 16'h1234, 1'b0, 16'h5678);
        repeat (3) step(1'b0, 16'h1234, 1'b0, 16'h5678);
        // Round robin from idle: last owner was 0, so 1 wins, then 0 wins
        repeat (2) step(1'b1, 16'h1111, 1'b1, 16'h2222);
        repeat (2) step(1'b0, 16'h1111, 1'b0, 16'h2222);
        repeat (2) step(1'b1, 16'h1111, 1'b1, 16'h2222);
        repeat (2) step(1'b0, 16'h1111, 1'b0, 16'h2222);
        // Sanitize
        repeat (3) step(1'b1, 16'h9ABC, 1'b0, 16'h0000);
        repeat (3) step(1'b1, 16'h0F50, 1'b0, 16'h0000);
        repeat (2) step(1'b0, 16'h0F50, 1'b0, 16'h0000);
        // Reset mid-OWN1, both requests high across release
        repeat (3) step(1'b0, 16'h1234, 1'b1, 16'h4321);
        step(1'b1, 16'h1234, 1'b1, 16'h4321);
        do_reset();
        repeat (6) step(1'b1, 16'h1234, 1'b1, 16'h4321);
        // Randomized phase: sticky requests, mixed valid/invalid BCD data
        a = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) a = ~a;
            if ($urandom_range(0, 5) == 0) b = ~b;
            da = 16'($urandom);
            db = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                da = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            step(a, da, b, db);
            if ($urandom_range(0, 199) == 0) do_reset();
        end
        repeat (2) @(posedge clk);
        #3;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
